// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Streams bytes into instruction-memory words and holds the core
//               in reset until a complete image has been written.
//               Bytes are accepted one per cycle on a valid/ready handshake and
//               packed little-endian into INSTR_W-bit words. Each finished word
//               is written with a single-cycle we pulse on the following cycle.
//               Assembly of the next word continues during that pulse, so there
//               are no gaps in the byte stream.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               start, num_words    - load request and word count (IDLE/DONE only)
//               in_valid, in_data   - byte stream input
//               in_ready            - byte accepted this cycle when in_valid=1
//               we, waddr, wdata    - instruction memory write port
//               busy, done          - load in progress / last load completed
//               core_rst_n          - core reset, released only in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W:0]     num_words,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                we,
    output logic [ADDR_W-1:0]   waddr,
    output logic [INSTR_W-1:0]  wdata,
    output logic                busy,
    output logic                done,
    output logic                core_rst_n
);

    localparam int c_BPW = INSTR_W / 8;
    localparam int c_BCW = (c_BPW > 1) ? $clog2(c_BPW) : 1;
    localparam int c_CW  = ADDR_W + 1;

    localparam logic [c_BCW-1:0] c_LAST_BYTE = c_BCW'(c_BPW - 1);
    localparam logic [c_CW-1:0]  c_DEPTH     = c_CW'(1) << ADDR_W;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_BCW-1:0]   r_byte_cnt;
    // Counts words whose last byte has been accepted (written + pending).
    // One bit wider than waddr so a full-depth load does not wrap.
    logic [c_CW-1:0]    r_word_cnt;
    logic [c_CW-1:0]    r_num;
    logic [INSTR_W-1:0] r_asm;

    logic               w_accept;
    logic               w_last_byte;
    logic [c_CW-1:0]    w_num_sat;
    logic [INSTR_W-1:0] w_word;

    assign in_ready    = (r_state == c_ST_LOAD) && (r_word_cnt < r_num);
    assign w_accept    = in_valid && in_ready;
    assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);
    assign w_num_sat   = (num_words > c_DEPTH) ? c_DEPTH : num_words;

    // Partial word with the incoming byte merged into its lane.
    always_comb begin
        w_word = r_asm;
        w_word[8*int'(r_byte_cnt) +: 8] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_num      <= '0;
            r_asm      <= '0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            core_rst_n <= 1'b0;
        end else begin
            we <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_byte_cnt <= '0;
                        r_word_cnt <= '0;
                        r_num      <= w_num_sat;
                        r_asm      <= '0;
                        // done and core_rst_n drop for at least one cycle even
                        // for an empty load, so a new completion is visible.
                        done       <= 1'b0;
                        core_rst_n <= 1'b0;
                        if (w_num_sat == '0) begin
                            r_state <= c_ST_DONE;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= c_ST_LOAD;
                            busy    <= 1'b1;
                        end
                    end else if (r_state == c_ST_DONE) begin
                        done       <= 1'b1;
                        core_rst_n <= 1'b1;
                    end
                end
                c_ST_LOAD: begin
                    if (w_accept) begin
                        r_asm <= w_word;
                        if (w_last_byte) begin
                            r_byte_cnt <= '0;
                            r_word_cnt <= r_word_cnt + c_CW'(1);
                            we         <= 1'b1;
                            waddr      <= r_word_cnt[ADDR_W-1:0];
                            wdata      <= w_word;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + c_BCW'(1);
                        end
                    end
                    // Leave LOAD at the end of the cycle carrying the final
                    // write, so busy covers that write cycle.
                    if (we && (r_word_cnt == r_num)) begin
                        r_state    <= c_ST_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        core_rst_n <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Expected writes come from
//               a word-list model: word i is bytes 4i..4i+3 little-endian, for
//               i below min(num_words, 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W  = 5;
    localparam int INSTR_W = 32;
    localparam int BPW     = INSTR_W / 8;
    localparam int DEPTH   = 1 << ADDR_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [ADDR_W:0]    num_words = '0;
    logic               in_valid = 1'b0;
    logic [7:0]         in_data = '0;
    logic               in_ready;
    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [INSTR_W-1:0] wdata;
    logic               busy;
    logic               done;
    logic               core_rst_n;

    imem_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_words  (num_words),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .core_rst_n (core_rst_n)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [7:0]         stim[$];
    logic [ADDR_W-1:0]  obs_addr[$];
    logic [INSTR_W-1:0] obs_data[$];
    int                 obs_cyc[$];
    int                 we_nobusy  = 0;
    int                 ready_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            obs_addr.push_back(waddr);
            obs_data.push_back(wdata);
            obs_cyc.push_back(cyc);
            if (busy !== 1'b1) we_nobusy++;
        end
        if (in_ready === 1'b1) ready_seen++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic int eff_words(input int n);
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    function automatic logic [INSTR_W-1:0] model_word(input int i);
        logic [INSTR_W-1:0] w = '0;
        for (int k = 0; k < BPW; k++)
            w = w | (INSTR_W'(stim[i*BPW + k]) << (8*k));
        return w;
    endfunction

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        we_nobusy  = 0;
        ready_seen = 0;
    endtask

    task automatic fill_random(input int nbytes);
        stim.delete();
        for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
    endtask

    // Called at a negedge. Returns the cycle number in which start was held.
    task automatic run_load(input int n, input bit gaps, input bit poke_start, output int c0);
        int nbytes = eff_words(n) * BPW;
        int idx    = 0;
        int budget = nbytes * 20 + 50;
        clear_obs();
        start     = 1'b1;
        num_words = (ADDR_W+1)'(n);
        c0        = cyc;
        @(negedge clk);
        start = 1'b0;
        while (idx < nbytes && budget > 0) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = stim[idx];
            if (poke_start && idx == 3) begin
                start     = 1'b1;
                num_words = (ADDR_W+1)'(1);
            end else begin
                start = 1'b0;
            end
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            budget--;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (budget == 0) check("byte_budget", 64'(idx), 64'(nbytes));
        check("in_ready_after_last", 64'(in_ready), 64'd0);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("done_reached", 64'(done), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic verify_writes(input string tag, input int n);
        int ne = eff_words(n);
        check({tag, "_we_count"}, 64'(obs_addr.size()), 64'(ne));
        for (int i = 0; i < ne && i < obs_addr.size(); i++) begin
            check({tag, "_waddr"}, 64'(obs_addr[i]), 64'(i));
            check({tag, "_wdata"}, 64'(obs_data[i]), 64'(model_word(i)));
        end
        check({tag, "_busy_on_we"}, 64'(we_nobusy), 64'd0);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'd1);
        check({tag, "_we_idle"}, 64'(we), 64'd0);
        if (ne > 0) begin
            check({tag, "_waddr_hold"}, 64'(waddr), 64'(ne - 1));
            check({tag, "_wdata_hold"}, 64'(wdata), 64'(model_word(ne - 1)));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, 64'(we), 64'd0);
        check({tag, "_waddr"}, 64'(waddr), 64'd0);
        check({tag, "_wdata"}, 64'(wdata), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    task automatic load_basic_bytes();
        stim.delete();
        stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    endtask

    initial begin
        int c0;
        int n;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_in_ready", 64'(in_ready), 64'd0);
        check("idle_core_rst_n", 64'(core_rst_n), 64'd0);

        // Basic continuous load with fixed timing
        load_basic_bytes();
        run_load(2, 1'b0, 1'b0, c0);
        wait_done();
        verify_writes("basic", 2);
        check("basic_word0", 64'(model_word(0)), 64'h13);
        if (obs_cyc.size() == 2) begin
            check("basic_we0_cycle", 64'(obs_cyc[0] - c0), 64'd5);
            check("basic_we1_cycle", 64'(obs_cyc[1] - c0), 64'd9);
        end

        // Same bytes with random in_valid gaps
        run_load(2, 1'b1, 1'b0, c0);
        wait_done();
        verify_writes("gaps", 2);

        // Zero-length load from DONE: done dips one cycle, no writes
        clear_obs();
        start     = 1'b1;
        num_words = '0;
        @(negedge clk);
        start = 1'b0;
        check("zero_done_dip", 64'(done), 64'd0);
        check("zero_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("zero_done_back", 64'(done), 64'd1);
        repeat (3) @(negedge clk);
        check("zero_we_count", 64'(obs_addr.size()), 64'd0);
        check("zero_in_ready_seen", 64'(ready_seen), 64'd0);

        // Full depth, then oversize request saturated to depth
        fill_random(DEPTH * BPW);
        run_load(DEPTH, 1'b0, 1'b0, c0);
        wait_done();
        verify_writes("full", DEPTH);
        run_load(63, 1'b1, 1'b0, c0);
        wait_done();
        verify_writes("sat63", 63);

        // start pulsed mid-load is ignored
        fill_random(3 * BPW);
        run_load(3, 1'b0, 1'b1, c0);
        wait_done();
        verify_writes("start_in_load", 3);

        // Randomized loads
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 40);
            fill_random(eff_words(n) * BPW);
            run_load(n, 1'($urandom_range(0, 1)), 1'b0, c0);
            wait_done();
            verify_writes("rand", n);
        end

        // Reset after 6 bytes of a 2-word load
        load_basic_bytes();
        clear_obs();
        start     = 1'b1;
        num_words = (ADDR_W+1)'(2);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = stim[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midreset_we_count", 64'(obs_addr.size()), 64'd1);
        check("midreset_idle_busy", 64'(busy), 64'd0);
        check("midreset_idle_done", 64'(done), 64'd0);
        run_load(2, 1'b0, 1'b0, c0);
        wait_done();
        verify_writes("after_reset", 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning the instruction memory word-address width.
REQ-002 SHALL have parameter INSTR_W, default 32, meaning the instruction word width; it must be a multiple of 8, and BPW = INSTR_W/8 bytes per word.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning an asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  meaning a load request, sampled only in IDLE or DONE.
REQ-006 SHALL have port num_words  input  ADDR_W+1  meaning the number of words to load, sampled with start.
REQ-007 SHALL have port in_valid  input  1  meaning a byte is offered on in_data.
REQ-008 SHALL have port in_data  input  8  meaning the offered byte.
REQ-009 SHALL have port in_ready  output  1  meaning the loader accepts a byte this cycle.
REQ-010 SHALL have port we  output  1  meaning the instruction memory write strobe.
REQ-011 SHALL have port waddr  output  ADDR_W  meaning the instruction memory word address.
REQ-012 SHALL have port wdata  output  INSTR_W  meaning the instruction memory write data.
REQ-013 SHALL have port busy  output  1  meaning a load is in progress.
REQ-014 SHALL have port done  output  1  meaning the last load has completed.
REQ-015 SHALL have port core_rst_n  output  1  meaning the core reset; it is low while the memory image is not valid.

Function
REQ-016 SHALL implement states IDLE, LOAD and DONE.
REQ-017 SHALL accept a byte only on a cycle where in_valid=1 and in_ready=1.
REQ-018 SHALL drive in_ready=1 only in LOAD while words_written + words_pending < num_words_latched.
REQ-019 SHALL assemble each word little-endian: the first accepted byte goes to bits [7:0] and byte k goes to bits [8k+7:8k].
REQ-020 SHALL, on the cycle after the BPW-th byte of a word is accepted, pulse we=1 for exactly one cycle, with waddr = word index (from 0) and wdata = the assembled word.
REQ-021 SHALL keep accepting bytes of the next word while we is pulsing, so there are no bubbles; sustained throughput is 1 byte/cycle.
REQ-022 SHALL keep waddr and wdata stable (last written values) when we=0.
REQ-023 SHALL transition IDLE/DONE->LOAD on start=1, latch num_words, clear the byte and word counters, and drive done=0.
REQ-024 SHALL, in IDLE/DONE with start=1 and num_words=0, go directly to DONE with no writes, and pulse done 0 for one cycle before re-asserting it.
REQ-025 SHALL saturate num_words > 2**ADDR_W to 2**ADDR_W; the final waddr is then 2**ADDR_W-1 and the word counter must not wrap.
REQ-026 SHALL transition LOAD->DONE on the cycle the final we pulse is issued; in that same cycle busy=1, and from the next cycle busy=0 and done=1.
REQ-027 SHALL ignore start while in LOAD.
REQ-028 SHALL hold done=1 in DONE until the next accepted start.
REQ-029 SHALL hold the partial-word assembly across cycles with in_valid=0; there is no timeout.
REQ-030 SHALL drive busy=1 exactly in LOAD, including the final write cycle.
REQ-031 SHALL drive core_rst_n=0 in IDLE and LOAD, and core_rst_n=1 only in DONE, registered with no glitches.
REQ-032 SHALL drive all outputs from registers, except in_ready, which may be combinational from state and counters.

Reset
REQ-033 SHALL, on rst_n=0, asynchronously force state=IDLE, we=0, waddr=0, wdata=0, busy=0, done=0, core_rst_n=0, in_ready=0, and clear the counters.
REQ-034 SHALL, on reset mid-LOAD, discard any partial word and issue no further we; after reset release it waits for a new start.
REQ-035 SHALL, on the first clock edge after rst_n rises, remain in IDLE until start=1.

Verification
REQ-036 Basic load: start, num_words=2, bytes 13 00 00 00 93 00 10 00 streamed continuously -> we pulses at cycles 5 and 9 after start, writing waddr0=0x00000013 and waddr1=0x00100093; then done=1 and core_rst_n=1.
REQ-037 Backpressure gaps: in_valid toggled randomly with the same 8 bytes -> identical writes, one we per word, and in_ready=0 after the 8th byte.
REQ-038 Zero length: start with num_words=0 -> no we, DONE reached within 2 cycles, in_ready never 1.
REQ-039 Full depth: num_words=32 with ADDR_W=5, 128 bytes -> 32 writes to waddr 0..31 in order; num_words=63 gives the same 32 writes.
REQ-040 Reset mid-load: rst_n low after 6 bytes -> outputs at reset values immediately, no write for the partial word; a following fresh start loads correctly.
REQ-041 Start during LOAD: pulse start with num_words=1 mid-load -> ignored; the original num_words completes.
